// File: rtl/accum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// accum_frame_ctrl
//
// Frame controller for an external accumulator. A frame of iLen samples is
// started with iStart, the accumulator is cleared for one cycle, the samples
// are streamed into it through oAccCe/oAccIn, and after one extra cycle of
// accumulator latency the sum is captured and presented on oSum/oSumValid
// until the consumer takes it with iSumReady.
//
// Ports
//   iClk, iRstN            clock, synchronous active-low reset
//   iStart, iLen           frame start request and frame length
//   iAbort                 cancel a frame in CLR/ACC/WAIT
//   iValid, iData, oReady  sample input handshake
//   oAccCe, oAccClr,
//   oAccIn, iAccSum        external accumulator interface (1-cycle latency)
//   oSum, oSumValid,
//   iSumReady              frame result handshake
//   oBusy, oCount          status: not idle / samples accepted this frame
// -----------------------------------------------------------------------------
module accum_frame_ctrl #(
  parameter int DW = 12,
  parameter int SW = 32,
  parameter int LW = 16
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iStart,
  input  logic [LW-1:0] iLen,
  input  logic          iAbort,
  input  logic          iValid,
  input  logic [DW-1:0] iData,
  output logic          oReady,
  output logic          oAccCe,
  output logic          oAccClr,
  output logic [DW-1:0] oAccIn,
  input  logic [SW-1:0] iAccSum,
  output logic [SW-1:0] oSum,
  output logic          oSumValid,
  input  logic          iSumReady,
  output logic          oBusy,
  output logic [LW-1:0] oCount
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] count_q, count_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          sum_valid_q, sum_valid_d;
  logic          ready_s;
  logic          clr_s;
  logic [LW-1:0] count_inc_s;

  assign count_inc_s = count_q + {{(LW-1){1'b0}}, 1'b1};

  // Next-state and frame bookkeeping
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    ready_s     = 1'b0;
    clr_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          len_d   = iLen;
          count_d = {LW{1'b0}};
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLR: begin
        clr_s = 1'b1;
        if (iAbort) begin
          count_d = {LW{1'b0}};
          state_d = S_IDLE;
        end else if (len_q != {LW{1'b0}}) begin
          state_d = S_ACC;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_ACC: begin
        if (iAbort) begin
          // Abort wins over a concurrent sample: ready is dropped so no
          // accumulate happens, and the accumulator is cleared instead.
          clr_s   = 1'b1;
          count_d = {LW{1'b0}};
          state_d = S_IDLE;
        end else begin
          ready_s = 1'b1;
          if (iValid) begin
            count_d = count_inc_s;
            if (count_inc_s == len_q) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_ACC;
            end
          end else begin
            state_d = S_ACC;
          end
        end
      end

      S_WAIT: begin
        if (iAbort) begin
          clr_s   = 1'b1;
          count_d = {LW{1'b0}};
          state_d = S_IDLE;
        end else begin
          // Last accumulate was issued one cycle ago, so iAccSum is final now.
          sum_d       = iAccSum;
          sum_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end

      S_OUT: begin
        if (iSumReady) begin
          sum_valid_d = 1'b0;
          if (iStart) begin
            len_d   = iLen;
            count_d = {LW{1'b0}};
            state_d = S_CLR;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_OUT;
        end
      end

      default: begin
        state_d     = S_IDLE;
        count_d     = {LW{1'b0}};
        sum_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_q     <= S_IDLE;
      len_q       <= {LW{1'b0}};
      count_q     <= {LW{1'b0}};
      sum_q       <= {SW{1'b0}};
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  // Reset forces the accumulator cleared and idle regardless of state.
  assign oReady    = ready_s & iRstN;
  assign oAccCe    = iValid & oReady;
  assign oAccClr   = clr_s | ~iRstN;
  assign oAccIn    = iData;
  assign oSum      = sum_q;
  assign oSumValid = sum_valid_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oCount    = count_q;

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for accum_frame_ctrl. A behavioural accumulator closes the loop on
// oAccCe/oAccClr/oAccIn -> iAccSum. Expected frame sums are pushed to a queue
// when a frame is started and popped when oSumValid appears.
// -----------------------------------------------------------------------------
module tb_accum_frame_ctrl;

  localparam int DW = 12;
  localparam int SW = 32;
  localparam int LW = 16;

  logic          iClk;
  logic          iRstN;
  logic          iStart;
  logic [LW-1:0] iLen;
  logic          iAbort;
  logic          iValid;
  logic [DW-1:0] iData;
  logic          oReady;
  logic          oAccCe;
  logic          oAccClr;
  logic [DW-1:0] oAccIn;
  logic [SW-1:0] iAccSum;
  logic [SW-1:0] oSum;
  logic          oSumValid;
  logic          iSumReady;
  logic          oBusy;
  logic [LW-1:0] oCount;

  accum_frame_ctrl #(.DW(DW), .SW(SW), .LW(LW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iLen(iLen), .iAbort(iAbort),
    .iValid(iValid), .iData(iData), .oReady(oReady), .oAccCe(oAccCe),
    .oAccClr(oAccClr), .oAccIn(oAccIn), .iAccSum(iAccSum), .oSum(oSum),
    .oSumValid(oSumValid), .iSumReady(iSumReady), .oBusy(oBusy), .oCount(oCount)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            clr_cnt = 0;
  int            ce_cnt = 0;
  int            start_cyc = 0;
  int            last_acc_cyc = 0;
  int            res_cyc = 0;
  logic [SW-1:0] acc_q = '0;
  logic [DW-1:0] smp [16];
  logic [SW-1:0] exp_q [$];

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Cycle counter
  always @(posedge iClk) cyc <= cyc + 1;

  // Behavioural accumulator with one cycle of latency
  always @(posedge iClk) begin
    if (oAccClr) acc_q <= '0;
    else if (oAccCe) acc_q <= acc_q + {{(SW-DW){1'b0}}, oAccIn};
  end
  assign iAccSum = acc_q;

  // Pulse monitors
  always @(negedge iClk) begin
    if (iRstN && oAccClr) clr_cnt <= clr_cnt + 1;
    if (oAccCe) ce_cnt <= ce_cnt + 1;
  end

  task automatic step();
    @(posedge iClk); #1;
  endtask

  function automatic logic [SW-1:0] ref_sum(input int n);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + {{(SW-DW){1'b0}}, smp[k]};
    return s;
  endfunction

  // Accept iStart in IDLE; leaves the bench positioned in the CLR cycle.
  task automatic start_frame(input int len, input bit push);
    iStart = 1'b1;
    iLen   = LW'(len);
    if (push) exp_q.push_back(ref_sum(len));
    @(negedge iClk);
    start_cyc = cyc;
    step();
    iStart = 1'b0;
  endtask

  // Stream n samples from smp[]; gap inserts an idle cycle after each accept,
  // poke holds iStart high with a bogus length throughout.
  task automatic feed(input int n, input bit gap, input bit poke);
    int  i;
    int  guard;
    bit  acc;
    i = 0;
    guard = 0;
    iValid = 1'b1;
    iData  = smp[0];
    if (poke) begin
      iStart = 1'b1;
      iLen   = 16'd9;
    end
    while (i < n && guard < 200) begin
      @(negedge iClk);
      acc = oReady && iValid;
      if (acc) last_acc_cyc = cyc;
      step();
      guard++;
      if (acc) begin
        i++;
        if (gap) begin
          iValid = 1'b0;
          iData  = 12'hFFF;
        end else begin
          iData = smp[i % 16];
        end
      end else if (gap) begin
        iValid = 1'b1;
        iData  = smp[i % 16];
      end
    end
    iValid = 1'b0;
    iStart = 1'b0;
    n_vec++;
    if (i != n) begin
      n_err++;
      $display("FAIL feed_accepts: got %0d accepts, need %0d", i, n);
    end
  endtask

  // Wait for oSumValid, then pop and compare the sum and final count.
  task automatic wait_result(input int exp_cnt);
    int            guard;
    bit            got;
    logic [SW-1:0] e;
    guard = 0;
    got = 1'b0;
    while (!got && guard < 100) begin
      @(negedge iClk);
      if (oSumValid) got = 1'b1;
      else begin
        step();
        guard++;
      end
    end
    res_cyc = cyc;
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL result_timeout: oSumValid never rose, need 1");
    end else begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: oSum=%0d with empty scoreboard", oSum);
      end else begin
        e = exp_q.pop_front();
        if (oSum !== e) begin
          n_err++;
          $display("FAIL result_sum: oSum=%0d, need %0d", oSum, e);
        end
      end
      n_vec++;
      if (oCount !== LW'(exp_cnt)) begin
        n_err++;
        $display("FAIL result_count: oCount=%0d, need %0d", oCount, exp_cnt);
      end
    end
  endtask

  // One-cycle result handshake, optionally starting the next frame.
  task automatic handshake(input bit st, input int len);
    iSumReady = 1'b1;
    iStart    = st;
    iLen      = LW'(len);
    @(negedge iClk);
    n_vec++;
    if (oSumValid !== 1'b1) begin
      n_err++;
      $display("FAIL hs_valid: oSumValid=%0b, need 1", oSumValid);
    end
    step();
    iSumReady = 1'b0;
    iStart    = 1'b0;
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    iValid = 1'b1;
    repeat (3) step();
    @(negedge iClk);
    n_vec++;
    if ({oBusy, oSumValid, oAccCe, oAccClr, oReady} !== 5'b00010 || oSum !== '0 || oCount !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy/sv/ce/clr/rdy=%b sum=%0d cnt=%0d, need 00010 0 0",
               {oBusy, oSumValid, oAccCe, oAccClr, oReady}, oSum, oCount);
    end
    step();
    iValid = 1'b0;
    iRstN  = 1'b1;
    step();
  endtask

  task automatic test_basic();
    smp[0] = 12'd1; smp[1] = 12'd2; smp[2] = 12'd3; smp[3] = 12'd4;
    clr_cnt = 0;
    start_frame(4, 1'b1);
    feed(4, 1'b0, 1'b0);
    wait_result(4);
    n_vec++;
    if (res_cyc - last_acc_cyc != 2) begin
      n_err++;
      $display("FAIL basic_accept_latency: %0d cycles, need 2", res_cyc - last_acc_cyc);
    end
    n_vec++;
    if (res_cyc - start_cyc != 7) begin
      n_err++;
      $display("FAIL basic_start_latency: %0d cycles, need 7", res_cyc - start_cyc);
    end
    n_vec++;
    if (clr_cnt != 1) begin
      n_err++;
      $display("FAIL basic_clr_pulses: %0d, need 1", clr_cnt);
    end
    step();
    handshake(1'b0, 0);
    @(negedge iClk);
    n_vec++;
    if (oSumValid !== 1'b0 || oBusy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: sv=%0b busy=%0b, need 0 0", oSumValid, oBusy);
    end
    step();
  endtask

  task automatic test_backpressure();
    smp[0] = 12'd5; smp[1] = 12'd7; smp[2] = 12'd9;
    start_frame(3, 1'b1);
    feed(3, 1'b1, 1'b0);
    wait_result(3);
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge iClk);
      n_vec++;
      if (oSumValid !== 1'b1 || oSum !== 32'd21) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: sv=%0b sum=%0d, need 1 21", k, oSumValid, oSum);
      end
    end
    step();
    handshake(1'b0, 0);
    @(negedge iClk);
    n_vec++;
    if (oSumValid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: sv=%0b, need 0", oSumValid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    smp[0] = 12'd10; smp[1] = 12'd20; smp[2] = 12'd30;
    start_frame(3, 1'b1);
    feed(3, 1'b0, 1'b0);
    wait_result(3);
    step();
    smp[0] = 12'd100; smp[1] = 12'd200;
    exp_q.push_back(ref_sum(2));
    iSumReady = 1'b1;
    iStart    = 1'b1;
    iLen      = 16'd2;
    @(negedge iClk);
    n_vec++;
    if (oSum !== 32'd60) begin
      n_err++;
      $display("FAIL b2b_first: oSum=%0d, need 60", oSum);
    end
    step();
    iSumReady = 1'b0;
    iStart    = 1'b0;
    @(negedge iClk);
    n_vec++;
    if (oAccClr !== 1'b1 || oCount !== '0 || oSumValid !== 1'b0 || oBusy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_clr: clr=%0b cnt=%0d sv=%0b busy=%0b, need 1 0 0 1",
               oAccClr, oCount, oSumValid, oBusy);
    end
    feed(2, 1'b0, 1'b0);
    wait_result(2);
    step();
    handshake(1'b0, 0);
  endtask

  task automatic test_zero_len();
    ce_cnt = 0;
    start_frame(0, 1'b1);
    wait_result(0);
    n_vec++;
    if (res_cyc - start_cyc != 3) begin
      n_err++;
      $display("FAIL zero_latency: %0d cycles, need 3", res_cyc - start_cyc);
    end
    n_vec++;
    if (ce_cnt != 0) begin
      n_err++;
      $display("FAIL zero_ce: %0d enables, need 0", ce_cnt);
    end
    step();
    handshake(1'b0, 0);
  endtask

  task automatic test_ignored_start();
    smp[0] = 12'd3; smp[1] = 12'd4; smp[2] = 12'd5;
    start_frame(3, 1'b1);
    feed(3, 1'b0, 1'b1);
    iStart = 1'b1;
    iLen   = 16'd9;
    wait_result(3);
    step();
    @(negedge iClk);
    n_vec++;
    if (oSumValid !== 1'b1 || oCount !== 16'd3) begin
      n_err++;
      $display("FAIL ign_out_start: sv=%0b cnt=%0d, need 1 3", oSumValid, oCount);
    end
    iStart = 1'b0;
    step();
    handshake(1'b0, 0);
  endtask

  task automatic test_abort_reset();
    int sv_seen;
    for (int k = 0; k < 8; k++) smp[k] = DW'(k + 1);
    start_frame(8, 1'b0);
    feed(3, 1'b0, 1'b0);
    iValid = 1'b1;
    iAbort = 1'b1;
    @(negedge iClk);
    n_vec++;
    if (oAccCe !== 1'b0 || oAccClr !== 1'b1) begin
      n_err++;
      $display("FAIL abort_drive: ce=%0b clr=%0b, need 0 1", oAccCe, oAccClr);
    end
    step();
    iAbort = 1'b0;
    iValid = 1'b0;
    @(negedge iClk);
    n_vec++;
    if (oBusy !== 1'b0 || oCount !== '0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%0b cnt=%0d, need 0 0", oBusy, oCount);
    end
    sv_seen = 0;
    repeat (6) begin
      step();
      @(negedge iClk);
      if (oSumValid) sv_seen++;
    end
    n_vec++;
    if (sv_seen != 0) begin
      n_err++;
      $display("FAIL abort_no_result: %0d valid cycles, need 0", sv_seen);
    end
    step();
    smp[0] = 12'd7;
    start_frame(1, 1'b1);
    feed(1, 1'b0, 1'b0);
    wait_result(1);
    step();
    handshake(1'b0, 0);
    // Reset during ACC
    smp[0] = 12'd50;
    start_frame(4, 1'b0);
    feed(1, 1'b0, 1'b0);
    iValid = 1'b1;
    iRstN  = 1'b0;
    @(negedge iClk);
    n_vec++;
    if (oAccClr !== 1'b1 || oAccCe !== 1'b0) begin
      n_err++;
      $display("FAIL rst_drive: clr=%0b ce=%0b, need 1 0", oAccClr, oAccCe);
    end
    step();
    @(negedge iClk);
    n_vec++;
    if (oBusy !== 1'b0 || oCount !== '0 || oSumValid !== 1'b0 || oSum !== '0) begin
      n_err++;
      $display("FAIL rst_state: busy=%0b cnt=%0d sv=%0b sum=%0d, need 0 0 0 0",
               oBusy, oCount, oSumValid, oSum);
    end
    iRstN  = 1'b1;
    iValid = 1'b0;
    sv_seen = 0;
    repeat (8) begin
      step();
      @(negedge iClk);
      if (oSumValid || oBusy) sv_seen++;
    end
    n_vec++;
    if (sv_seen != 0) begin
      n_err++;
      $display("FAIL rst_idle: %0d busy/valid cycles, need 0", sv_seen);
    end
    step();
  endtask

  initial begin
    iRstN = 1'b0; iStart = 1'b0; iLen = '0; iAbort = 1'b0;
    iValid = 1'b0; iData = '0; iSumReady = 1'b0;
    for (int k = 0; k < 16; k++) smp[k] = '0;
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_zero_len();
    test_ignored_start();
    test_abort_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d results outstanding, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
